// File: rtl/sim_io_bridge.sv
// ============================================================================
// sim_io_bridge : harness-side reset stretcher, PS/2 key FIFO, pixel expander
// Rev 1.0
// ============================================================================
`default_nettype none

module sim_io_bridge #(
  parameter int BPP         = 1,
  parameter int MODE        = 0,
  parameter int KEY_DEPTH   = 8,
  parameter int RST_STRETCH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ioctl_download,
  input  logic [10:0]                  ps2_key,
  output logic                         core_reset,
  output logic                         key_valid,
  output logic [9:0]                   key_data,
  input  logic                         key_ready,
  output logic [$clog2(KEY_DEPTH):0]   key_count,
  output logic                         key_overflow,
  input  logic                         ce_pix,
  input  logic [BPP-1:0]               pix_in,
  input  logic                         hs_in,
  input  logic                         vs_in,
  input  logic                         hb_in,
  input  logic                         vb_in,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic                         VGA_HB,
  output logic                         VGA_VB
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(RST_STRETCH + 1);
  localparam logic [CW-1:0] C_FULL_CNT     = CW'(KEY_DEPTH);
  localparam logic [SW-1:0] C_STRETCH_LOAD = SW'(RST_STRETCH);

  if (BPP < 1 || BPP > 4) begin : g_bad_bpp
    $error("sim_io_bridge: BPP must be 1..4");
  end
  if (MODE != 0 && !(MODE == 1 && BPP >= 3)) begin : g_bad_mode
    $error("sim_io_bridge: MODE must be 0, or 1 with BPP>=3");
  end
  if (KEY_DEPTH < 2 || (KEY_DEPTH & (KEY_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sim_io_bridge: KEY_DEPTH must be a power of 2 >= 2");
  end
  if (RST_STRETCH < 1) begin : g_bad_stretch
    $error("sim_io_bridge: RST_STRETCH must be >= 1");
  end

  // ---------------- reset stretch ----------------
  logic [SW-1:0] stretch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   stretch_q <= C_STRETCH_LOAD;
    else if (ioctl_download)     stretch_q <= C_STRETCH_LOAD;
    else if (stretch_q != '0)    stretch_q <= stretch_q - 1'b1;
  end

  assign core_reset = ioctl_download | (stretch_q != '0);

  // ---------------- strobe sampler ----------------
  logic old_q, primed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      old_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      old_q    <= ps2_key[10];
      primed_q <= 1'b1;
    end
  end

  logic w_event;
  assign w_event = primed_q & (old_q ^ ps2_key[10]) & ~ioctl_download;

  // ---------------- key FIFO (first-word-fall-through) ----------------
  logic [9:0]    mem_q [KEY_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          w_full, w_pop, w_push, w_drop;

  assign w_full = (count_q == C_FULL_CNT);
  // An empty FIFO never pops, so push+pop on empty degenerates to push only.
  assign w_pop  = key_valid & key_ready;
  assign w_push = w_event & (~w_full | w_pop);
  assign w_drop = w_event & w_full & ~w_pop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KEY_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (ioctl_download) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= ps2_key[9:0];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (w_drop) overflow_q <= 1'b1;
    end
  end

  assign key_valid    = (count_q != '0);
  assign key_data     = mem_q[rd_ptr_q];
  assign key_count    = count_q;
  assign key_overflow = overflow_q;

  // ---------------- pixel expansion ----------------
  logic [7:0] w_r, w_g, w_b;

  if (MODE == 0) begin : g_grey
    logic [7:0] w_grey;
    for (genvar i = 0; i < 8; i++) begin : g_rep
      assign w_grey[7-i] = pix_in[BPP-1-(i % BPP)];
    end
    assign w_r = w_grey;
    assign w_g = w_grey;
    assign w_b = w_grey;
  end else if (BPP == 3) begin : g_rgb
    assign w_r = {8{pix_in[1]}};
    assign w_g = {8{pix_in[2]}};
    assign w_b = {8{pix_in[0]}};
  end else if (BPP == 4) begin : g_rgbi
    // bit3 is intensity: lifts off-level to 55 and on-level from AA to FF
    assign w_r = pix_in[1] ? (pix_in[3] ? 8'hFF : 8'hAA) : (pix_in[3] ? 8'h55 : 8'h00);
    assign w_g = pix_in[2] ? (pix_in[3] ? 8'hFF : 8'hAA) : (pix_in[3] ? 8'h55 : 8'h00);
    assign w_b = pix_in[0] ? (pix_in[3] ? 8'hFF : 8'hAA) : (pix_in[3] ? 8'h55 : 8'h00);
  end else begin : g_none
    assign w_r = 8'h00;
    assign w_g = 8'h00;
    assign w_b = 8'h00;
  end

  logic w_blank;
  assign w_blank = hb_in | vb_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R  <= 8'h00;
      VGA_G  <= 8'h00;
      VGA_B  <= 8'h00;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
      VGA_HB <= 1'b0;
      VGA_VB <= 1'b0;
    end else if (ce_pix) begin
      VGA_R  <= w_blank ? 8'h00 : w_r;
      VGA_G  <= w_blank ? 8'h00 : w_g;
      VGA_B  <= w_blank ? 8'h00 : w_b;
      VGA_HS <= hs_in;
      VGA_VS <= vs_in;
      VGA_HB <= hb_in;
      VGA_VB <= vb_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sim_io_bridge.sv
// ============================================================================
// tb_sim_io_bridge : directed self-checking bench for sim_io_bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sim_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [10:0] ps2_key;
  logic        key_ready;
  logic        ce_pix;
  logic [1:0]  pix0;
  logic [3:0]  pix1;
  logic        hs_in, vs_in, hb_in, vb_in;

  logic        core_reset0, key_valid0, key_overflow0;
  logic [9:0]  key_data0;
  logic [3:0]  key_count0;
  logic [7:0]  r0, g0, b0;
  logic        hs0, vs0, hb0, vb0;

  logic        core_reset1, key_valid1, key_overflow1;
  logic [9:0]  key_data1;
  logic [3:0]  key_count1;
  logic [7:0]  r1, g1, b1;
  logic        hs1, vs1, hb1, vb1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_io_bridge #(.BPP(2), .MODE(0), .KEY_DEPTH(8), .RST_STRETCH(16)) u_dut0 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ps2_key(ps2_key),
    .core_reset(core_reset0), .key_valid(key_valid0), .key_data(key_data0),
    .key_ready(key_ready), .key_count(key_count0), .key_overflow(key_overflow0),
    .ce_pix(ce_pix), .pix_in(pix0), .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_HB(hb0), .VGA_VB(vb0)
  );

  sim_io_bridge #(.BPP(4), .MODE(1), .KEY_DEPTH(8), .RST_STRETCH(16)) u_dut1 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ps2_key(ps2_key),
    .core_reset(core_reset1), .key_valid(key_valid1), .key_data(key_data1),
    .key_ready(key_ready), .key_count(key_count1), .key_overflow(key_overflow1),
    .ce_pix(ce_pix), .pix_in(pix1), .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_HB(hb1), .VGA_VB(vb1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] payload);
    ps2_key = {~ps2_key[10], payload};
    tick();
  endtask

  initial begin
    logic [9:0] exp_q[$];

    reset = 1'b1; ioctl_download = 1'b0; ps2_key = {1'b1, 10'h000};
    key_ready = 1'b0; ce_pix = 1'b0; pix0 = '0; pix1 = '0;
    hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
    #2;
    check("rst_core_reset", 32'(core_reset0), 32'd1);
    check("rst_key_valid", 32'(key_valid0), 32'd0);
    check("rst_key_count", 32'(key_count0), 32'd0);
    check("rst_key_data", 32'(key_data0), 32'd0);
    check("rst_overflow", 32'(key_overflow0), 32'd0);
    check("rst_vga", {r0, g0, b0, hs0, vs0, hb0, vb0, 4'd0}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // ps2_key[10] held high through release: priming must not push
    repeat (3) tick();
    check("prime_no_push", 32'(key_count0), 32'd0);

    // reset stretch around a 5-clock download pulse
    ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dl_core_reset", 32'(core_reset0), 32'd1);
    end
    ioctl_download = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("stretch_hold_%0d", i), 32'(core_reset0), 32'd1);
    end
    tick();
    check("stretch_release_16", 32'(core_reset0), 32'd0);

    // first toggle
    ps2_key = {1'b0, 10'h21C};
    tick();
    check("first_valid", 32'(key_valid0), 32'd1);
    check("first_data", 32'(key_data0), 32'h21C);
    check("first_count", 32'(key_count0), 32'd1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("first_pop_count", 32'(key_count0), 32'd0);

    // overflow: 9 events into depth 8
    for (int i = 1; i <= 9; i++) send(10'(10'h100 + i));
    check("ovf_count", 32'(key_count0), 32'd8);
    check("ovf_flag", 32'(key_overflow0), 32'd1);
    check("ovf_head", 32'(key_data0), 32'h101);
    key_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(key_data0), 32'(10'h100 + i));
      tick();
    end
    key_ready = 1'b0;
    check("drain_empty", 32'(key_valid0), 32'd0);
    check("ovf_sticky", 32'(key_overflow0), 32'd1);

    ioctl_download = 1'b1;
    send(10'h3AA);
    ioctl_download = 1'b0;
    tick();
    check("dl_clears_ovf", 32'(key_overflow0), 32'd0);
    check("dl_ignores_event", 32'(key_count0), 32'd0);

    // full push+pop
    for (int i = 1; i <= 8; i++) begin
      send(10'(10'h200 + i));
      exp_q.push_back(10'(10'h200 + i));
    end
    check("full_count", 32'(key_count0), 32'd8);
    key_ready = 1'b1;
    send(10'h2FF);
    void'(exp_q.pop_front());
    exp_q.push_back(10'h2FF);
    check("fpp_count", 32'(key_count0), 32'd8);
    check("fpp_no_ovf", 32'(key_overflow0), 32'd0);
    check("fpp_head", 32'(key_data0), 32'h202);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fpp_drain_%0d", i), 32'(key_data0), 32'(exp_q[i]));
      tick();
    end
    check("fpp_empty", 32'(key_valid0), 32'd0);

    // push+pop on empty: push only
    send(10'h0F0);
    key_ready = 1'b0;
    check("epp_count", 32'(key_count0), 32'd1);
    check("epp_data", 32'(key_data0), 32'h0F0);

    // video MODE 0 BPP 2
    ce_pix = 1'b1; pix0 = 2'b10; hs_in = 1'b1; vs_in = 1'b1;
    tick();
    check("grey_aa", {8'd0, r0, g0, b0}, 32'h00AAAAAA);
    check("grey_sync", {30'd0, hs0, vs0}, 32'd3);
    ce_pix = 1'b0; pix0 = 2'b01; hs_in = 1'b0;
    tick();
    check("grey_hold", {8'd0, r0, g0, b0}, 32'h00AAAAAA);
    check("grey_hold_hs", 32'(hs0), 32'd1);
    ce_pix = 1'b1;
    tick();
    check("grey_55", {8'd0, r0, g0, b0}, 32'h00555555);
    check("grey_hs_low", 32'(hs0), 32'd0);
    pix0 = 2'b10; hb_in = 1'b1;
    tick();
    check("hblank_rgb", {8'd0, r0, g0, b0}, 32'd0);
    check("hblank_flag", 32'(hb0), 32'd1);
    hb_in = 1'b0; vb_in = 1'b1;
    tick();
    check("vblank_rgb", {8'd0, r0, g0, b0}, 32'd0);
    check("vblank_flag", {30'd0, hb0, vb0}, 32'd1);
    vb_in = 1'b0;

    // video MODE 1 BPP 4
    pix1 = 4'b0110;
    tick();
    check("rgbi_0110", {8'd0, r1, g1, b1}, 32'h00AAAA00);
    pix1 = 4'b1001;
    tick();
    check("rgbi_1001", {8'd0, r1, g1, b1}, 32'h005555FF);
    pix1 = 4'b1111;
    tick();
    check("rgbi_1111", {8'd0, r1, g1, b1}, 32'h00FFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
